systolic_ctrl: RTL

Sequencer for an N×N output-stationary systolic MAC array built from `systolic_unit` PEs. On a start request it does four things:
- clears every PE accumulator;
- drives skewed per-lane read addresses and lane enables into the A-row and B-column operand buffers for K products;
- waits for the wavefront to drain;
- pulses `done` when every PE `c_out` holds its final dot product.

It sits between the host/command logic and the operand feeders of the array.

---
 rtl/systolic_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an N x N output-stationary systolic MAC array.
// It clears the PE accumulators, then feeds skewed lane addresses for K
// products, then drains the wavefront and pulses done.

// Per-lane enable/address decode. Lane i is live for FEED cycles i .. i+K-1
// and carries operand index t-i.
module systolic_lane #(
  parameter int K_W  = 8,
  parameter int CW   = 11,
  parameter int LANE = 0
) (
  input  logic           feed,
  input  logic [CW-1:0]  t,
  input  logic [K_W-1:0] k,
  output logic           en,
  output logic [K_W-1:0] addr
);
  logic [CW-1:0] rel;

  // Offset of this lane into the skewed wavefront.
  always_comb begin
    rel  = t - CW'(LANE);
    en   = feed && (t >= CW'(LANE)) && (rel < CW'(k));
    addr = en ? rel[K_W-1:0] : '0;
  end
endmodule

module systolic_ctrl #(
  parameter int N   = 4,
  parameter int K_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [K_W-1:0]   k_len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             pe_clr,
  output logic [N-1:0]     lane_en,
  output logic [N*K_W-1:0] lane_addr
);
  // Cycle counter spans FEED and DRAIN: up to K_max+2N-3 without wrapping.
  localparam int CW = K_W + $clog2(N) + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       t_q, t_d;
  logic [K_W-1:0]      k_q, k_d;
  logic                err_d;
  logic [CW-1:0]       feed_end, drain_end;
  logic [N-1:0]        en_d;
  logic [N-1:0][K_W-1:0] addr_d;

  // Last FEED cycle is t=K+N-2; the last PE accumulate lands at t=K+2N-3.
  // For N=1 the N-2 term wraps, but the modular sum still yields K-1.
  assign feed_end  = CW'(k_q) + CW'(N - 2);
  assign drain_end = CW'(k_q) + CW'(2 * N - 3);

  // Next-state, counter and error-pulse logic; abort overrides sequencing.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    k_d     = k_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        t_d = '0;
        if (start) begin
          if (k_len != '0) begin
            k_d     = k_len;
            state_d = CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        t_d     = '0;
        state_d = FEED;
      end
      FEED: begin
        t_d = t_q + 1'b1;
        if (t_q == feed_end) state_d = (N == 1) ? DONE : DRAIN;
      end
      DRAIN: begin
        t_d = t_q + 1'b1;
        if (t_q == drain_end) state_d = DONE;
      end
      DONE: begin
        t_d     = '0;
        state_d = IDLE;
      end
      default: begin
        t_d     = '0;
        state_d = IDLE;
      end
    endcase
    if (abort && (state_q == CLEAR || state_q == FEED || state_q == DRAIN)) begin
      state_d = IDLE;
      t_d     = '0;
    end
  end

  // Lane decode works on next-cycle state so the outputs can be registered.
  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_lane #(.K_W(K_W), .CW(CW), .LANE(i)) u_lane (
      .feed (state_d == FEED),
      .t    (t_d),
      .k    (k_d),
      .en   (en_d[i]),
      .addr (addr_d[i])
    );
  end

  // State and counters plus registered copies of every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      t_q       <= '0;
      k_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pe_clr    <= 1'b0;
      lane_en   <= '0;
      lane_addr <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      k_q       <= k_d;
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
      err       <= err_d;
      pe_clr    <= (state_d == CLEAR);
      lane_en   <= en_d;
      lane_addr <= addr_d;
    end
  end
endmodule
